// File: rtl/load_store_unit_if.sv
// Bus bundle between the core/memory side (master) and the load/store unit (slave).
// The master drives request fields and the memory return path; the slave drives
// the response and the memory access fields.
interface load_store_unit_if #(
  parameter int WORD_SIZE = 32
);
  // core request channel
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_store;
  logic [2:0]             req_funct3;
  logic [WORD_SIZE-1:0]   req_addr;
  logic [WORD_SIZE-1:0]   req_wdata;

  // core response channel
  logic                   resp_valid;
  logic [WORD_SIZE-1:0]   resp_rdata;
  logic                   resp_error;

  // data memory channel
  logic                   mem_req;
  logic [WORD_SIZE-1:0]   mem_address;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic [WORD_SIZE/8-1:0] mem_wstrb;
  logic [WORD_SIZE-1:0]   mem_rdata;
  logic                   mem_done;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_done,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_req, mem_address, mem_wdata, mem_wstrb
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_done,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_req, mem_address, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit. One request at a time: legality check,
// a single word-aligned memory access with byte strobes, bounded wait for the
// memory, and sign/zero extension of load data. Every output is a register.
module load_store_unit #(
  parameter int WORD_SIZE      = 32,  // only 32 is supported
  parameter int TIMEOUT_CYCLES = 255  // 1..255 WAIT cycles before abort
) (
  input  logic              clk_i,
  input  logic              rst_i,
  load_store_unit_if.slave  bus
);

  localparam int STRB_W = WORD_SIZE / 8;
  // last counter value at which a missing mem_done turns into a timeout
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_e;

  state_e               state_q;
  logic                 store_q;
  logic [2:0]           funct3_q;
  // only the byte offset is needed after accept; the word address and the
  // lane-positioned store data go straight into the memory output registers
  logic [1:0]           addr_lo_q;
  logic [7:0]           tmo_cnt_q;

  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic [WORD_SIZE-1:0] resp_rdata_q;
  logic                 resp_error_q;
  logic                 mem_req_q;
  logic [WORD_SIZE-1:0] mem_address_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;
  logic [STRB_W-1:0]    mem_wstrb_q;

  // request decode, computed from the live request fields for use on accept
  logic                 illegal_d;
  logic [STRB_W-1:0]    wstrb_d;
  logic [WORD_SIZE-1:0] wdata_d;

  // load extraction, computed from the live memory word for use in WAIT
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] load_data_d;

  // legality check of the incoming request
  always_comb begin
    illegal_d = 1'b0;
    case (bus.req_funct3)
      F3_B:  illegal_d = 1'b0;
      F3_BU: illegal_d = bus.req_store;
      F3_H:  illegal_d = bus.req_addr[0];
      F3_HU: illegal_d = bus.req_store | bus.req_addr[0];
      F3_W:  illegal_d = (bus.req_addr[1:0] != 2'b00);
      default: illegal_d = 1'b1;
    endcase
  end

  // byte strobes and lane-replicated store data; loads write nothing
  always_comb begin
    wstrb_d = '0;
    wdata_d = '0;
    if (bus.req_store) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << bus.req_addr[1:0];
          wdata_d = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.req_wdata[15:0]}};
        end
        2'b10: begin
          wstrb_d = 4'b1111;
          wdata_d = bus.req_wdata;
        end
        default: begin
          wstrb_d = '0;
          wdata_d = '0;
        end
      endcase
    end
  end

  // select the addressed byte/half of the memory word and extend it
  always_comb begin
    ld_byte = 8'h00;
    case (addr_lo_q)
      2'd0: ld_byte = bus.mem_rdata[7:0];
      2'd1: ld_byte = bus.mem_rdata[15:8];
      2'd2: ld_byte = bus.mem_rdata[23:16];
      2'd3: ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    load_data_d = '0;
    case (funct3_q)
      F3_B:  load_data_d = {{24{ld_byte[7]}}, ld_byte};
      F3_BU: load_data_d = {24'h000000, ld_byte};
      F3_H:  load_data_d = {{16{ld_half[15]}}, ld_half};
      F3_HU: load_data_d = {16'h0000, ld_half};
      F3_W:  load_data_d = bus.mem_rdata;
      default: load_data_d = '0;
    endcase
  end

  // control FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      store_q       <= 1'b0;
      funct3_q      <= 3'b000;
      addr_lo_q     <= 2'b00;
      tmo_cnt_q     <= 8'd0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
    end else begin
      // single-cycle pulses default low
      resp_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            store_q     <= bus.req_store;
            funct3_q    <= bus.req_funct3;
            addr_lo_q   <= bus.req_addr[1:0];
            req_ready_q <= 1'b0;
            if (illegal_d) begin
              // rejected without touching memory
              state_q      <= S_RESPOND;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q       <= S_ISSUE;
              mem_req_q     <= 1'b1;
              mem_address_q <= {bus.req_addr[WORD_SIZE-1:2], 2'b00};
              mem_wstrb_q   <= wstrb_d;
              mem_wdata_q   <= wdata_d;
            end
          end
        end

        S_ISSUE: begin
          state_q   <= S_WAIT;
          tmo_cnt_q <= 8'd0;
        end

        S_WAIT: begin
          if (bus.mem_done) begin
            // completion wins even on the last allowed cycle
            state_q      <= S_RESPOND;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= store_q ? '0 : load_data_d;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q      <= S_RESPOND;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end

        S_RESPOND: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.WORD_SIZE(32)) bus ();

  load_store_unit #(
    .WORD_SIZE      (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // observations captured by run_req
  int          obs_resp_cyc;
  int          obs_resp_cnt;
  int          obs_mreq_cnt;
  logic [31:0] obs_rdata;
  logic        obs_error;
  logic [31:0] obs_addr;
  logic [3:0]  obs_wstrb;
  logic [31:0] obs_wdata;
  logic        obs_hold_bad;
  logic        obs_ready_bad;
  logic        obs_ready_after;

  // directed vectors (load word 0x80123456)
  localparam logic [2:0]  LD_F3   [0:6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
  localparam logic [31:0] LD_ADDR [0:6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
  localparam logic [31:0] LD_EXP  [0:6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012,
                                            32'h00000056, 32'h00003456, 32'h00000034};

  localparam logic [2:0]  ST_F3    [0:4] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
  localparam logic [31:0] ST_ADDR  [0:4] = '{32'h201, 32'h202, 32'h204, 32'h203, 32'h200};
  localparam logic [31:0] ST_WD    [0:4] = '{32'h000000AB, 32'h00001234, 32'hCAFEF00D, 32'h1234567F, 32'hABCD8765};
  localparam logic [31:0] ST_EADDR [0:4] = '{32'h200, 32'h200, 32'h204, 32'h200, 32'h200};
  localparam logic [3:0]  ST_ESTRB [0:4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
  localparam logic [31:0] ST_EWD   [0:4] = '{32'hABABABAB, 32'h12341234, 32'hCAFEF00D, 32'h7F7F7F7F, 32'h87658765};

  localparam logic        IL_ST   [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [2:0]  IL_F3   [0:5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001, 3'b111};
  localparam logic [31:0] IL_ADDR [0:5] = '{32'h102, 32'h203, 32'h100, 32'h100, 32'h101, 32'h100};

  // Drive one request (called on a falling edge with the unit idle) and act as
  // the memory: mem_done is raised in WAIT cycle number done_at (0 = first),
  // never if done_at < 0. Cycle n is the n-th falling edge after acceptance.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int done_at);
    int issue_cyc;
    issue_cyc       = -1;
    obs_resp_cyc    = -1;
    obs_resp_cnt    = 0;
    obs_mreq_cnt    = 0;
    obs_rdata       = 'x;
    obs_error       = 1'bx;
    obs_addr        = 'x;
    obs_wstrb       = 'x;
    obs_wdata       = 'x;
    obs_hold_bad    = 1'b0;
    obs_ready_bad   = 1'b0;
    obs_ready_after = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = ~rd;
      if (obs_resp_cyc >= 0 && cyc == obs_resp_cyc + 1) begin
        obs_ready_after = bus.req_ready;
        if (bus.resp_valid) obs_resp_cnt++;
        break;
      end
      if (bus.req_ready !== 1'b0) obs_ready_bad = 1'b1;
      if (bus.mem_req === 1'b1) begin
        obs_mreq_cnt++;
        issue_cyc = cyc;
        obs_addr  = bus.mem_address;
        obs_wstrb = bus.mem_wstrb;
        obs_wdata = bus.mem_wdata;
      end else if (issue_cyc > 0 && bus.resp_valid !== 1'b1) begin
        if (bus.mem_address !== obs_addr || bus.mem_wstrb !== obs_wstrb ||
            bus.mem_wdata !== obs_wdata)
          obs_hold_bad = 1'b1;
        if (cyc - issue_cyc - 1 == done_at) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      if (bus.resp_valid === 1'b1) begin
        obs_resp_cnt++;
        obs_resp_cyc = cyc;
        obs_rdata    = bus.resp_rdata;
        obs_error    = bus.resp_error;
      end
    end
    bus.mem_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h0;
    bus.mem_done   = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.mem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {bus.resp_valid, bus.resp_error, bus.mem_req});
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_address, bus.mem_wdata, bus.mem_wstrb} !== 100'd0) begin
      errors++; $display("FAIL reset_data: got rdata %h addr %h wdata %h wstrb %b expected all 0",
                         bus.resp_rdata, bus.mem_address, bus.mem_wdata, bus.mem_wstrb);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.resp_valid, bus.req_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_req_ignored: got mem_req/resp/ready %b expected 001",
                         {bus.mem_req, bus.resp_valid, bus.req_ready});
    end
  endtask

  task automatic test_lw();
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checks++;
    if (obs_mreq_cnt !== 1) begin errors++; $display("FAIL lw_mem_req_count: got %0d expected 1", obs_mreq_cnt); end
    checks++;
    if (obs_addr !== 32'h100) begin errors++; $display("FAIL lw_address: got %h expected 00000100", obs_addr); end
    checks++;
    if (obs_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_wstrb: got %b expected 0000", obs_wstrb); end
    checks++;
    if (obs_resp_cyc !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", obs_resp_cyc); end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", obs_rdata); end
    checks++;
    if (obs_error !== 1'b0) begin errors++; $display("FAIL lw_error: got %b expected 0", obs_error); end
    checks++;
    if (obs_ready_bad !== 1'b0 || obs_ready_after !== 1'b1) begin
      errors++; $display("FAIL lw_ready: got busy_bad %b ready_after %b expected 0 1", obs_ready_bad, obs_ready_after);
    end
    checks++;
    if (obs_hold_bad !== 1'b0 || obs_resp_cnt !== 1) begin
      errors++; $display("FAIL lw_hold_pulse: got hold_bad %b resp_cnt %0d expected 0 1", obs_hold_bad, obs_resp_cnt);
    end
    $display("lw 0x100: resp cycle %0d rdata %h error %b", obs_resp_cyc, obs_rdata, obs_error);
  endtask

  task automatic test_load_ext();
    for (int i = 0; i <= 6; i++) begin
      run_req(1'b0, LD_F3[i], LD_ADDR[i], 32'h0, 32'h80123456, 0);
      checks++;
      if (obs_rdata !== LD_EXP[i] || obs_error !== 1'b0 || obs_resp_cyc !== 3) begin
        errors++;
        $display("FAIL load_ext[%0d]: got rdata %h err %b cyc %0d expected %h 0 3",
                 i, obs_rdata, obs_error, obs_resp_cyc, LD_EXP[i]);
      end
      checks++;
      if (obs_addr !== 32'h100 || obs_wstrb !== 4'b0000) begin
        errors++; $display("FAIL load_addr[%0d]: got addr %h wstrb %b expected 00000100 0000", i, obs_addr, obs_wstrb);
      end
      $display("load f3=%b addr %h: rdata %h", LD_F3[i], LD_ADDR[i], obs_rdata);
    end
  endtask

  task automatic test_store();
    for (int i = 0; i <= 4; i++) begin
      run_req(1'b1, ST_F3[i], ST_ADDR[i], ST_WD[i], 32'h5555AAAA, 0);
      checks++;
      if (obs_addr !== ST_EADDR[i] || obs_wstrb !== ST_ESTRB[i] || obs_wdata !== ST_EWD[i]) begin
        errors++;
        $display("FAIL store_bus[%0d]: got addr %h wstrb %b wdata %h expected %h %b %h",
                 i, obs_addr, obs_wstrb, obs_wdata, ST_EADDR[i], ST_ESTRB[i], ST_EWD[i]);
      end
      checks++;
      if (obs_rdata !== 32'h0 || obs_error !== 1'b0 || obs_resp_cyc !== 3 || obs_hold_bad !== 1'b0) begin
        errors++;
        $display("FAIL store_resp[%0d]: got rdata %h err %b cyc %0d hold_bad %b expected 0 0 3 0",
                 i, obs_rdata, obs_error, obs_resp_cyc, obs_hold_bad);
      end
      $display("store f3=%b addr %h: wstrb %b wdata %h", ST_F3[i], ST_ADDR[i], obs_wstrb, obs_wdata);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i <= 5; i++) begin
      run_req(IL_ST[i], IL_F3[i], IL_ADDR[i], 32'hFFFFFFFF, 32'h12345678, 0);
      checks++;
      if (obs_resp_cyc !== 1 || obs_error !== 1'b1 || obs_rdata !== 32'h0) begin
        errors++;
        $display("FAIL illegal_resp[%0d]: got cyc %0d err %b rdata %h expected 1 1 0",
                 i, obs_resp_cyc, obs_error, obs_rdata);
      end
      checks++;
      if (obs_mreq_cnt !== 0 || obs_ready_after !== 1'b1) begin
        errors++;
        $display("FAIL illegal_mem[%0d]: got mem_req count %0d ready_after %b expected 0 1",
                 i, obs_mreq_cnt, obs_ready_after);
      end
      $display("illegal st=%b f3=%b addr %h: cyc %0d error %b", IL_ST[i], IL_F3[i], IL_ADDR[i], obs_resp_cyc, obs_error);
    end
  endtask

  task automatic test_timeout();
    logic late_bad;
    // no mem_done: 4 WAIT cycles (2..5), error response in cycle 6
    run_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, -1);
    checks++;
    if (obs_resp_cyc !== 6 || obs_error !== 1'b1 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: got cyc %0d err %b rdata %h expected 6 1 0", obs_resp_cyc, obs_error, obs_rdata);
    end
    $display("timeout: cyc %0d error %b", obs_resp_cyc, obs_error);
    // late done arrives while idle
    late_bad = 1'b0;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) late_bad = 1'b1;
    end
    checks++;
    if (late_bad !== 1'b0) begin errors++; $display("FAIL timeout_late_done: got disturbed %b expected 0", late_bad); end
    // done on the last allowed WAIT cycle completes normally
    run_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0F0F1234, 3);
    checks++;
    if (obs_resp_cyc !== 6 || obs_error !== 1'b0 || obs_rdata !== 32'h0F0F1234) begin
      errors++; $display("FAIL timeout_last_done: got cyc %0d err %b rdata %h expected 6 0 0f0f1234",
                         obs_resp_cyc, obs_error, obs_rdata);
    end
    // one extra wait cycle adds one cycle of latency
    run_req(1'b0, 3'b001, 32'h402, 32'h0, 32'h7FFF0000, 1);
    checks++;
    if (obs_resp_cyc !== 4 || obs_error !== 1'b0 || obs_rdata !== 32'h00007FFF || obs_hold_bad !== 1'b0) begin
      errors++; $display("FAIL wait_one: got cyc %0d err %b rdata %h hold_bad %b expected 4 0 00007fff 0",
                         obs_resp_cyc, obs_error, obs_rdata, obs_hold_bad);
    end
    $display("late done on 4th wait / 1 extra wait: done");
  endtask

  task automatic test_reset_midflight();
    logic stray;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h100;
    @(negedge clk);               // ISSUE
    bus.req_valid = 1'b0;
    @(negedge clk);               // WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state: got resp_valid %b ready %b expected 0 1", bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h22223333;
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL midreset_done_ignored: got stray %b expected 0", stray); end
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0);
    checks++;
    if (obs_resp_cyc !== 3 || obs_rdata !== 32'h0BADF00D || obs_error !== 1'b0) begin
      errors++; $display("FAIL midreset_next_lw: got cyc %0d rdata %h err %b expected 3 0badf00d 0",
                         obs_resp_cyc, obs_rdata, obs_error);
    end
    $display("reset in WAIT: next lw cyc %0d rdata %h", obs_resp_cyc, obs_rdata);
  endtask

  task automatic test_back_to_back();
    int mreq_cnt, resp_cnt, last_mreq, last_resp;
    logic [31:0] first_rdata;
    mreq_cnt = 0; resp_cnt = 0; last_mreq = -1; last_resp = -1;
    first_rdata = 'x;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h300;
    bus.mem_done   = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin mreq_cnt++; last_mreq = cyc; end
      if (bus.resp_valid === 1'b1) begin
        if (resp_cnt == 0) first_rdata = bus.resp_rdata;
        resp_cnt++; last_resp = cyc;
      end
    end
    bus.req_valid = 1'b0;
    bus.mem_done  = 1'b0;
    checks++;
    if (mreq_cnt !== 3 || last_mreq !== 9) begin
      errors++; $display("FAIL b2b_issue: got %0d issues last at %0d expected 3 at 9", mreq_cnt, last_mreq);
    end
    checks++;
    if (resp_cnt !== 3 || last_resp !== 11 || first_rdata !== 32'h12345678) begin
      errors++; $display("FAIL b2b_resp: got %0d resps last at %0d rdata %h expected 3 at 11 12345678",
                         resp_cnt, last_resp, first_rdata);
    end
    $display("back-to-back: %0d issues, %0d responses", mreq_cnt, resp_cnt);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_illegal();
    test_timeout();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
